// File: rtl/spu_sm_seq_if.sv
// gbuf port and lane-datapath strobes of the softmax sequencer.
// master = sequencer side, slave = gbuf/datapath side.
interface spu_sm_seq_if #(
    parameter int ADDR_WIDTH = 12,
    parameter int LANES      = 4,
    parameter int DATA_WIDTH = 32
);
    logic                        sm_gbuf_ren;
    logic [ADDR_WIDTH-1:0]       sm_gbuf_raddr;
    logic                        sm_gbuf_wen;
    logic [ADDR_WIDTH-1:0]       sm_gbuf_waddr;
    logic [LANES*DATA_WIDTH-1:0] sm_gbuf_wdata;
    logic [1:0]                  dp_pass;
    logic                        dp_vld;
    logic                        dp_row_first;
    logic                        dp_recip_start;
    logic                        dp_recip_done;
    logic [LANES*DATA_WIDTH-1:0] dp_wdata;

    modport master (
        output sm_gbuf_ren, sm_gbuf_raddr, sm_gbuf_wen, sm_gbuf_waddr, sm_gbuf_wdata,
        output dp_pass, dp_vld, dp_row_first, dp_recip_start,
        input  dp_recip_done, dp_wdata
    );
    modport slave (
        input  sm_gbuf_ren, sm_gbuf_raddr, sm_gbuf_wen, sm_gbuf_waddr, sm_gbuf_wdata,
        input  dp_pass, dp_vld, dp_row_first, dp_recip_start,
        output dp_recip_done, dp_wdata
    );
endinterface

// File: rtl/spu_sm_seq.sv
// Softmax row sequencer: MAX, EXP, RECI, NORM passes over gbuf rows.
// Optional SM_SKIP_MAX_EN adds cfg_skip_max to start each row directly in EXP.
module spu_sm_seq #(
    parameter int ADDR_WIDTH = 12,
    parameter int LANES      = 4,
    parameter int DATA_WIDTH = 32,
    parameter int RLATENCY   = 1,
    parameter int EXP_LAT    = 3,
    parameter int MUL_LAT    = 2
) (
    input  logic                  core_clk,
    input  logic                  rst_n,
    input  logic                  sm_start,
    input  logic                  sm_abort,
    output logic                  sm_busy,
    output logic                  sm_end,
    input  logic [ADDR_WIDTH-1:0] cfg_rows,
    input  logic [ADDR_WIDTH-1:0] cfg_words,
    input  logic [ADDR_WIDTH-1:0] cfg_im_base,
    input  logic [ADDR_WIDTH-1:0] cfg_om_base,
    input  logic [ADDR_WIDTH-1:0] cfg_im_stride,
    input  logic [ADDR_WIDTH-1:0] cfg_om_stride,
`ifdef SM_SKIP_MAX_EN
    input  logic                  cfg_skip_max,
`endif
    spu_sm_seq_if.master          bus
);
    localparam int CW = ADDR_WIDTH + 8;
    localparam int ED = RLATENCY + EXP_LAT;
    localparam int ND = RLATENCY + MUL_LAT;

    typedef enum logic [2:0] {S_IDLE, S_MAX, S_EXP, S_RECI, S_NORM, S_EMPTY} state_t;

    state_t                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] wcnt_q, wcnt_d;
    logic [ADDR_WIDTH-1:0] rows_q, rows_d, words_q, words_d;
    logic [ADDR_WIDTH-1:0] in_base_q, in_base_d, out_base_q, out_base_d;
    logic [ADDR_WIDTH-1:0] im_stride_q, im_stride_d, om_stride_q, om_stride_d;
    logic                  skip_q, skip_d, end_q, end_d;
    logic [RLATENCY-1:0]   vld_pipe_q, vld_pipe_d, rf_pipe_q, rf_pipe_d;
    logic [ED-1:0]         wexp_pipe_q, wexp_pipe_d;
    logic [ND-1:0]         wnorm_pipe_q, wnorm_pipe_d;

    logic [LANES*DATA_WIDTH-1:0] wdata;
    logic [CW-1:0] words_ext, max_last, exp_last, norm_last;
    logic          in_pass, ren, wen, row_first_in;
    state_t        first_st;

    assign words_ext = CW'(words_q);
    assign max_last  = words_ext + CW'(RLATENCY) - CW'(1);
    assign exp_last  = words_ext + CW'(ED) - CW'(1);
    assign norm_last = words_ext + CW'(ND) - CW'(1);
    assign first_st  = skip_q ? S_EXP : S_MAX;

    // Reads lead each pass; pipes drain inside the pass, so taps only see own-pass reads.
    assign in_pass      = (state_q == S_MAX) || (state_q == S_EXP) || (state_q == S_NORM);
    assign ren          = in_pass && (cnt_q < words_ext) && !sm_abort;
    assign row_first_in = ren && (cnt_q == '0) && (state_q == first_st);
    assign wen          = !sm_abort &&
                          (((state_q == S_EXP)  && wexp_pipe_q[ED-1]) ||
                           ((state_q == S_NORM) && wnorm_pipe_q[ND-1]));

    assign wdata              = bus.dp_wdata;
    assign bus.sm_gbuf_wdata  = wdata;
    assign bus.sm_gbuf_ren    = ren;
    assign bus.sm_gbuf_raddr  = ren ? (((state_q == S_NORM) ? out_base_q : in_base_q)
                                       + cnt_q[ADDR_WIDTH-1:0]) : '0;
    assign bus.sm_gbuf_wen    = wen;
    assign bus.sm_gbuf_waddr  = wen ? (out_base_q + wcnt_q) : '0;
    assign bus.dp_vld         = vld_pipe_q[RLATENCY-1] && !sm_abort;
    assign bus.dp_row_first   = rf_pipe_q[RLATENCY-1] && !sm_abort;
    assign bus.dp_recip_start = (state_q == S_RECI) && (cnt_q == '0) && !sm_abort;
    assign sm_busy            = (state_q != S_IDLE);
    assign sm_end             = end_q;

    always_comb begin
        bus.dp_pass = 2'd0;
        if (!sm_abort) begin
            case (state_q)
                S_MAX:   bus.dp_pass = 2'd1;
                S_EXP:   bus.dp_pass = 2'd2;
                S_NORM:  bus.dp_pass = 2'd3;
                default: bus.dp_pass = 2'd0;
            endcase
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q + CW'(1);
        wcnt_d       = wen ? wcnt_q + ADDR_WIDTH'(1) : wcnt_q;
        rows_d       = rows_q;
        words_d      = words_q;
        in_base_d    = in_base_q;
        out_base_d   = out_base_q;
        im_stride_d  = im_stride_q;
        om_stride_d  = om_stride_q;
        skip_d       = skip_q;
        end_d        = 1'b0;
        vld_pipe_d   = RLATENCY'({vld_pipe_q, ren});
        rf_pipe_d    = RLATENCY'({rf_pipe_q, row_first_in});
        wexp_pipe_d  = ED'({wexp_pipe_q, ren && (state_q == S_EXP)});
        wnorm_pipe_d = ND'({wnorm_pipe_q, ren && (state_q == S_NORM)});

        case (state_q)
            S_IDLE: begin
                cnt_d  = '0;
                wcnt_d = '0;
                if (sm_start) begin
                    rows_d      = cfg_rows;
                    words_d     = cfg_words;
                    in_base_d   = cfg_im_base;
                    out_base_d  = cfg_om_base;
                    im_stride_d = cfg_im_stride;
                    om_stride_d = cfg_om_stride;
`ifdef SM_SKIP_MAX_EN
                    skip_d = cfg_skip_max;
`else
                    skip_d = 1'b0;
`endif
                    if (cfg_rows == '0 || cfg_words == '0) state_d = S_EMPTY;
                    else state_d = skip_d ? S_EXP : S_MAX;
                end
            end
            S_EMPTY: begin
                state_d = S_IDLE;
                cnt_d   = '0;
                end_d   = 1'b1;
            end
            S_MAX: if (cnt_q == max_last) begin
                state_d = S_EXP;
                cnt_d   = '0;
                wcnt_d  = '0;
            end
            S_EXP: if (cnt_q == exp_last) begin
                state_d = S_RECI;
                cnt_d   = '0;
                wcnt_d  = '0;
            end
            S_RECI: begin
                // cnt only marks the first RECI cycle for the start pulse
                cnt_d = CW'(1);
                if (bus.dp_recip_done) begin
                    state_d = S_NORM;
                    cnt_d   = '0;
                end
            end
            S_NORM: if (cnt_q == norm_last) begin
                cnt_d      = '0;
                wcnt_d     = '0;
                in_base_d  = in_base_q + im_stride_q;
                out_base_d = out_base_q + om_stride_q;
                rows_d     = rows_q - ADDR_WIDTH'(1);
                if (rows_q == ADDR_WIDTH'(1)) begin
                    state_d = S_IDLE;
                    end_d   = 1'b1;
                end else begin
                    state_d = first_st;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (sm_abort) begin
            state_d      = S_IDLE;
            cnt_d        = '0;
            wcnt_d       = '0;
            end_d        = 1'b0;
            vld_pipe_d   = '0;
            rf_pipe_d    = '0;
            wexp_pipe_d  = '0;
            wnorm_pipe_d = '0;
        end
    end

    always_ff @(posedge core_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            wcnt_q       <= '0;
            rows_q       <= '0;
            words_q      <= '0;
            in_base_q    <= '0;
            out_base_q   <= '0;
            im_stride_q  <= '0;
            om_stride_q  <= '0;
            skip_q       <= 1'b0;
            end_q        <= 1'b0;
            vld_pipe_q   <= '0;
            rf_pipe_q    <= '0;
            wexp_pipe_q  <= '0;
            wnorm_pipe_q <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            wcnt_q       <= wcnt_d;
            rows_q       <= rows_d;
            words_q      <= words_d;
            in_base_q    <= in_base_d;
            out_base_q   <= out_base_d;
            im_stride_q  <= im_stride_d;
            om_stride_q  <= om_stride_d;
            skip_q       <= skip_d;
            end_q        <= end_d;
            vld_pipe_q   <= vld_pipe_d;
            rf_pipe_q    <= rf_pipe_d;
            wexp_pipe_q  <= wexp_pipe_d;
            wnorm_pipe_q <= wnorm_pipe_d;
        end
    end
endmodule

// File: tb/tb_spu_sm_seq.sv
// Directed bench for spu_sm_seq: a default-latency instance and an RLATENCY=2 instance.
module tb_spu_sm_seq;
    localparam int AW = 12;
    localparam int LN = 4;
    localparam int DW = 32;

    logic core_clk = 1'b0;
    logic rst_n = 1'b0;
    logic sm_start = 1'b0, sm_start2 = 1'b0, sm_abort = 1'b0;
    logic sm_busy, sm_end, sm_busy2, sm_end2;
    logic [AW-1:0] cfg_rows = '0, cfg_words = '0, cfg_im_base = '0, cfg_om_base = '0;
    logic [AW-1:0] cfg_im_stride = '0, cfg_om_stride = '0;
`ifdef SM_SKIP_MAX_EN
    logic cfg_skip_max = 1'b0;
`endif
    logic done = 1'b0;
    logic [LN*DW-1:0] wd = '0;

    spu_sm_seq_if #(.ADDR_WIDTH(AW), .LANES(LN), .DATA_WIDTH(DW)) bus ();
    spu_sm_seq_if #(.ADDR_WIDTH(AW), .LANES(LN), .DATA_WIDTH(DW)) bus2 ();
    assign bus.dp_recip_done  = done;
    assign bus.dp_wdata       = wd;
    assign bus2.dp_recip_done = done;
    assign bus2.dp_wdata      = wd;

    always #5 core_clk = ~core_clk;

    spu_sm_seq #(.ADDR_WIDTH(AW), .LANES(LN), .DATA_WIDTH(DW)) dut (
        .core_clk(core_clk), .rst_n(rst_n), .sm_start(sm_start), .sm_abort(sm_abort),
        .sm_busy(sm_busy), .sm_end(sm_end), .cfg_rows(cfg_rows), .cfg_words(cfg_words),
        .cfg_im_base(cfg_im_base), .cfg_om_base(cfg_om_base),
        .cfg_im_stride(cfg_im_stride), .cfg_om_stride(cfg_om_stride),
`ifdef SM_SKIP_MAX_EN
        .cfg_skip_max(cfg_skip_max),
`endif
        .bus(bus));

    spu_sm_seq #(.ADDR_WIDTH(AW), .LANES(LN), .DATA_WIDTH(DW), .RLATENCY(2)) dut2 (
        .core_clk(core_clk), .rst_n(rst_n), .sm_start(sm_start2), .sm_abort(sm_abort),
        .sm_busy(sm_busy2), .sm_end(sm_end2), .cfg_rows(cfg_rows), .cfg_words(cfg_words),
        .cfg_im_base(cfg_im_base), .cfg_om_base(cfg_om_base),
        .cfg_im_stride(cfg_im_stride), .cfg_om_stride(cfg_om_stride),
`ifdef SM_SKIP_MAX_EN
        .cfg_skip_max(1'b0),
`endif
        .bus(bus2));

    // observed-signal mux: sel picks which instance gets logged
    logic sel = 1'b0;
    logic ren_s, wen_s, end_s, busy_s, vld_s, rf_s, rs_s;
    logic [1:0] pass_s;
    logic [AW-1:0] raddr_s, waddr_s;
    assign ren_s   = sel ? bus2.sm_gbuf_ren    : bus.sm_gbuf_ren;
    assign wen_s   = sel ? bus2.sm_gbuf_wen    : bus.sm_gbuf_wen;
    assign raddr_s = sel ? bus2.sm_gbuf_raddr  : bus.sm_gbuf_raddr;
    assign waddr_s = sel ? bus2.sm_gbuf_waddr  : bus.sm_gbuf_waddr;
    assign end_s   = sel ? sm_end2             : sm_end;
    assign busy_s  = sel ? sm_busy2            : sm_busy;
    assign vld_s   = sel ? bus2.dp_vld         : bus.dp_vld;
    assign rf_s    = sel ? bus2.dp_row_first   : bus.dp_row_first;
    assign rs_s    = sel ? bus2.dp_recip_start : bus.dp_recip_start;
    assign pass_s  = sel ? bus2.dp_pass        : bus.dp_pass;

    int nchk = 0, nerr = 0, cyc = 0, rc = 0, nend = 0;
    logic [31:0] rd_q[$], wr_q[$];
    logic [1:0] pass_a[128];
    logic busy_a[128], end_a[128], rf_a[128], rs_a[128], vld_a[128];

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clr();
        cyc = 0; nend = 0;
        rd_q.delete(); wr_q.delete();
        for (int i = 0; i < 128; i++) begin
            pass_a[i] = 2'd0; busy_a[i] = 1'b0; end_a[i] = 1'b0;
            rf_a[i] = 1'b0; rs_a[i] = 1'b0; vld_a[i] = 1'b0;
        end
    endtask

    // one clock; recip_done answers 2 cycles after a sampled recip_start
    task automatic tick();
        @(posedge core_clk); #1;
        cyc++;
        done = 1'b0;
        if (rc > 0) begin rc--; if (rc == 0) done = 1'b1; end
        if (rs_s) rc = 2;
        if (ren_s) rd_q.push_back({cyc[15:0], 4'h0, raddr_s});
        if (wen_s) wr_q.push_back({cyc[15:0], 4'h0, waddr_s});
        if (end_s) nend++;
        if (cyc < 128) begin
            pass_a[cyc] = pass_s; busy_a[cyc] = busy_s; end_a[cyc] = end_s;
            rf_a[cyc] = rf_s; rs_a[cyc] = rs_s; vld_a[cyc] = vld_s;
        end
    endtask

    function automatic logic [31:0] ent(input int c, input int a);
        logic [15:0] cc, aa;
        cc = c[15:0]; aa = a[15:0];
        return {cc, aa};
    endfunction

    function automatic logic [31:0] qget(input logic [31:0] q[$], input int i);
        return (i < q.size()) ? q[i] : 32'hDEAD_BEEF;
    endfunction

    task automatic go(input int n);
        clr();
        if (sel) sm_start2 = 1'b1; else sm_start = 1'b1;
        tick();
        sm_start = 1'b0; sm_start2 = 1'b0;
        repeat (n) tick();
    endtask

    initial begin
        wd = {32'hCAFE_0003, 32'h1234_0002, 32'hA5A5_0001, 32'h0F0F_0000};
        #2;
        chk("rst_busy", sm_busy, 0);
        chk("rst_end", sm_end, 0);
        chk("rst_strobes", {bus.sm_gbuf_ren, bus.sm_gbuf_wen, bus.dp_vld,
                            bus.dp_row_first, bus.dp_recip_start, bus.dp_pass}, 0);
        chk("rst_addr", {bus.sm_gbuf_raddr, bus.sm_gbuf_waddr}, 0);
        chk("rst_wdata", bus.sm_gbuf_wdata, wd);
        @(posedge core_clk); #1; rst_n = 1'b1;

        // two rows, W=4, strides 8
        cfg_rows = 2; cfg_words = 4; cfg_im_base = 12'h000; cfg_om_base = 12'h100;
        cfg_im_stride = 8; cfg_om_stride = 8;
        go(52);
        chk("t1_nrd", rd_q.size(), 24);
        chk("t1_nwr", wr_q.size(), 16);
        for (int r = 0; r < 2; r++) begin
            for (int k = 0; k < 4; k++) begin
                int s;
                s = 1 + 23 * r;
                chk("t1_rd_max",  qget(rd_q, r*12 + k),     ent(s + k,      8*r + k));
                chk("t1_rd_exp",  qget(rd_q, r*12 + 4 + k), ent(s + 5 + k,  8*r + k));
                chk("t1_rd_norm", qget(rd_q, r*12 + 8 + k), ent(s + 16 + k, 'h100 + 8*r + k));
                chk("t1_wr_exp",  qget(wr_q, r*8 + k),      ent(s + 9 + k,  'h100 + 8*r + k));
                chk("t1_wr_norm", qget(wr_q, r*8 + 4 + k),  ent(s + 19 + k, 'h100 + 8*r + k));
            end
        end
        chk("t1_nend", nend, 1);
        chk("t1_end47", end_a[47], 1);
        chk("t1_busy46_47", {busy_a[46], busy_a[47]}, 2'b10);
        chk("t1_pass", {pass_a[1], pass_a[6], pass_a[14], pass_a[16], pass_a[17]}, 10'b01_10_00_00_11);
        chk("t1_rstart", {rs_a[13], rs_a[14], rs_a[15]}, 3'b010);
        chk("t1_rowfirst", {rf_a[2], rf_a[3], rf_a[7], rf_a[25]}, 4'b1001);
        chk("t1_vld", {vld_a[1], vld_a[2], vld_a[5], vld_a[6]}, 4'b0110);

        // empty job: rows=0
        cfg_rows = 0;
        go(5);
        chk("t2_busy", {busy_a[1], busy_a[2]}, 2'b10);
        chk("t2_end", {end_a[1], end_a[2], end_a[3]}, 3'b010);
        chk("t2_nend", nend, 1);
        chk("t2_noacc", rd_q.size() + wr_q.size(), 0);

        // start together with abort is dropped
        cfg_rows = 1; cfg_words = 4;
        clr(); sm_start = 1'b1; sm_abort = 1'b1;
        tick();
        sm_start = 1'b0; sm_abort = 1'b0;
        repeat (3) tick();
        chk("t3_busy", busy_a[1], 0);
        chk("t3_nrd", rd_q.size(), 0);

        // abort mid-EXP of row 0
        cfg_im_base = 12'h020; cfg_om_base = 12'h040; cfg_im_stride = 0; cfg_om_stride = 0;
        go(7);
        chk("t4_pre_ren", {pass_a[8], bus.sm_gbuf_ren}, 3'b101);
        sm_abort = 1'b1; #1;
        chk("t4_abort_strobes", {bus.sm_gbuf_ren, bus.sm_gbuf_wen, bus.dp_vld, bus.dp_pass}, 0);
        tick();
        sm_abort = 1'b0;
        repeat (20) tick();
        chk("t4_idle", busy_a[9], 0);
        chk("t4_nend", nend, 0);
        chk("t4_nwr", wr_q.size(), 0);
        chk("t4_nrd", rd_q.size(), 7);

        // clean restart with output row wrapping at the top of the address space
        cfg_om_base = 12'hFFE;
        go(26);
        chk("t5_nrd", rd_q.size(), 12);
        chk("t5_nwr", wr_q.size(), 8);
        for (int k = 0; k < 4; k++) begin
            chk("t5_wr_exp",  qget(wr_q, k),     ent(10 + k, (12'hFFE + k) & 12'hFFF));
            chk("t5_rd_norm", qget(rd_q, 8 + k), ent(17 + k, (12'hFFE + k) & 12'hFFF));
            chk("t5_wr_norm", qget(wr_q, 4 + k), ent(20 + k, (12'hFFE + k) & 12'hFFF));
        end
        chk("t5_end", {end_a[23], end_a[24]}, 2'b01);
        chk("t5_nend", nend, 1);

        // RLATENCY=2, one row of one word
        sel = 1'b1;
        cfg_words = 1; cfg_im_base = 12'h010; cfg_om_base = 12'h050;
        go(22);
        chk("t6_nrd", rd_q.size(), 3);
        chk("t6_rd", {qget(rd_q, 0), qget(rd_q, 1), qget(rd_q, 2)},
            {ent(1, 'h010), ent(4, 'h010), ent(13, 'h050)});
        chk("t6_wr", {qget(wr_q, 0), qget(wr_q, 1)}, {ent(9, 'h050), ent(17, 'h050)});
        chk("t6_vld", {vld_a[2], vld_a[3], vld_a[4]}, 3'b010);
        chk("t6_end", end_a[18], 1);
        chk("t6_nend", nend, 1);
        sel = 1'b0;

`ifdef SM_SKIP_MAX_EN
        cfg_skip_max = 1'b1;
        cfg_words = 3; cfg_im_base = 12'h000; cfg_om_base = 12'h200;
        go(20);
        chk("t7_pass1", pass_a[1], 2);
        chk("t7_rowfirst", {rf_a[2], vld_a[2]}, 2'b11);
        chk("t7_rd0", qget(rd_q, 0), ent(1, 'h000));
        chk("t7_nrd", rd_q.size(), 6);
        chk("t7_wr0", qget(wr_q, 0), ent(5, 'h200));
        chk("t7_end", end_a[17], 1);
        cfg_skip_max = 1'b0;
`endif

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end
endmodule

// File: doc/spu_sm_seq.md
# spu_sm_seq

Parametrised multi-lane softmax sequencer for the SPU. It runs three gbuf passes per row: MAX, then EXP (exp values written to the output row), then NORM (the output row is read back, multiplied by the reciprocal, and written in place). A reciprocal handshake with the lane datapath sits between EXP and NORM. The block sits between the SPU command decoder and the gbuf port. The lane datapath (max/exp/adder-tree/reciprocal/multiply) is external and driven through strobes.

## Interface
Parameters:
- ADDR_WIDTH, 12, gbuf address width.
- LANES, 4, elements per gbuf word.
- DATA_WIDTH, 32, bits per lane. Word width is LANES*DATA_WIDTH.
- RLATENCY, 1, gbuf read latency (ren to rdata), ≥1.
- EXP_LAT, 3, datapath latency from rdata to exp word.
- MUL_LAT, 2, datapath latency from rdata to normalised word.

Ports:
- core_clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- sm_start  in  1  start pulse; ignored while sm_busy.
- sm_abort  in  1  abort; returns to IDLE.
- sm_busy  out  1  state != IDLE.
- sm_end  out  1  one-cycle completion pulse.
- cfg_rows  in  ADDR_WIDTH  row count.
- cfg_words  in  ADDR_WIDTH  words per row (W).
- cfg_im_base, cfg_om_base  in  ADDR_WIDTH  first input and output row addresses.
- cfg_im_stride, cfg_om_stride  in  ADDR_WIDTH  row pitch for input and output.
- sm_gbuf_ren  out  1  read enable.
- sm_gbuf_raddr  out  ADDR_WIDTH  read address.
- sm_gbuf_wen  out  1  write enable.
- sm_gbuf_waddr  out  ADDR_WIDTH  write address.
- sm_gbuf_wdata  out  LANES*DATA_WIDTH  equal to dp_wdata (passthrough).
- dp_pass  out  2  0 idle, 1 max, 2 exp, 3 norm.
- dp_vld  out  1  gbuf rdata valid for current pass.
- dp_row_first  out  1  marks first dp_vld of a row; datapath clears max/sum.
- dp_recip_start  out  1  pulse requesting reciprocal of the row sum.
- dp_recip_done  in  1  reciprocal ready.
- dp_wdata  in  LANES*DATA_WIDTH  exp or normalised word from datapath.

## Operation
- All cfg_* inputs are latched on an accepted sm_start.
- If cfg_rows==0 or cfg_words==0, no gbuf access occurs and sm_end pulses 2 cycles after start.
- States: IDLE → MAX → EXP → RECI → NORM. After NORM, go to MAX if rows remain, otherwise IDLE.
- Each pass issues exactly W reads, one per cycle, starting in the first cycle of the state.
  - Read addresses are row_base+k, for k=0..W-1.
  - MAX and EXP read the input row. NORM reads the output row.
- dp_vld is ren delayed by RLATENCY. dp_pass holds the state encoding in every cycle of that state.
- Write strobes:
  - EXP: wen is ren delayed RLATENCY+EXP_LAT; waddr is out_row_base+k.
  - NORM: wen is ren delayed RLATENCY+MUL_LAT, same addresses.
  - MAX performs no writes.
- Pass length, exit on the last cycle:
  - MAX: W+RLATENCY cycles.
  - EXP: W+RLATENCY+EXP_LAT cycles.
  - NORM: W+RLATENCY+MUL_LAT cycles.
- RECI: dp_recip_start pulses in its first cycle. The state is held until dp_recip_done is seen high. dp_recip_done outside RECI is ignored.
- Row bases are updated at NORM exit: in_base += im_stride, out_base += om_stride. Addresses wrap modulo 2^ADDR_WIDTH.
- sm_end is registered and pulses the cycle after the last NORM cycle of the last row.
- sm_abort has priority over everything:
  - state goes to IDLE next edge;
  - ren, wen and dp_* are forced low combinationally in the abort cycle;
  - delay pipes are cleared;
  - sm_end is not pulsed.
- sm_start and sm_abort together: abort wins and the start is dropped.

## Timing
- Reset: state IDLE and counters/pipes 0. All outputs 0, except sm_gbuf_wdata, which follows dp_wdata.
- First read is issued the cycle after an accepted sm_start.
- EXP writes the final word before NORM reads it (RECI ≥1 cycle). No read-after-write hazard exists for any gbuf latency ≤ RLATENCY.
- Per-row cycles: (3W + 3·RLATENCY + EXP_LAT + MUL_LAT) plus the RECI cycles.

## Configuration
- SM_SKIP_MAX_EN: when defined, adds input cfg_skip_max (1 bit, latched at start).
  - When cfg_skip_max is set, each row starts in EXP and MAX is never entered.
  - dp_row_first then marks the first EXP dp_vld.
  - When undefined, the port is absent and MAX always runs.

## Test plan
- Rows=2, W=4, bases 0x000/0x100, strides 8/8, recip_done 2 cycles after start:
  - reads 0x000–003 ×2, then 0x100–103;
  - writes 0x100–103 twice, with row 2 at 0x008/0x108;
  - one sm_end pulse.
- Rows=1, W=1, RLATENCY=2: each pass issues 1 read; EXP wen occurs 5 cycles after its ren, NORM wen 4 cycles after its ren.
- cfg_rows=0: no ren or wen; sm_end pulses 2 cycles after start; sm_busy is high for 1 cycle.
- sm_abort mid-EXP of row 0: ren/wen low in the abort cycle, IDLE next cycle, no sm_end. A new start then runs row 0 cleanly.
- om_base=0xFFE, W=4: write addresses go 0xFFE, 0xFFF, 0x000, 0x001.
- SM_SKIP_MAX_EN with cfg_skip_max=1, W=3: first pass has dp_pass=2, with dp_row_first on its first dp_vld.
